// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressed data memory of 64-bit words for the MEM stage.
// Requests use a valid/ready handshake. One response pulse follows LATENCY
// cycles after acceptance. Handles b/h/w/d accesses, load sign/zero extension,
// and misalignment / out-of-range flags.
module dmem_sized #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_oob
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Wait-state preload; only used when LATENCY >= 2.
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 2);

    // Array contents are deliberately outside the reset domain.
    logic [63:0] mem_q [DEPTH] = '{0: 64'd1, 1: 64'd10, default: 64'd0};

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        oob_q, oob_d;

    logic [60:0]   widx;
    logic [2:0]    lane;
    logic [AW-1:0] mem_idx;
    logic          accept;
    logic          mis;
    logic          oob;
    logic          err;
    logic [7:0]    be;
    logic [7:0]    be_sh;
    logic [63:0]   wdata_sh;
    logic [63:0]   rd_word;
    logic [63:0]   rd_sh;
    logic [63:0]   ext;

    assign widx    = req_addr[63:3];
    assign lane    = req_addr[2:0];
    assign mem_idx = widx[AW-1:0];
    // Gated by rst_n so a request seen during reset can never touch the array.
    assign accept  = req_valid && (state_q == S_IDLE) && rst_n;
    // Full-width compare: huge addresses must not alias into the array.
    assign oob     = (widx >= 61'(DEPTH));
    assign err     = mis | oob;

    assign wdata_sh = req_wdata << {lane, 3'b000};
    assign be_sh    = be << lane;
    assign rd_word  = mem_q[mem_idx];
    assign rd_sh    = rd_word >> {lane, 3'b000};

    // Alignment check, byte-enable pattern and load extension per access size.
    always_comb begin
        mis = 1'b0;
        be  = 8'h00;
        ext = 64'd0;
        case (req_size)
            2'b00: begin
                be  = 8'h01;
                ext = req_unsigned ? {56'd0, rd_sh[7:0]} : {{56{rd_sh[7]}}, rd_sh[7:0]};
            end
            2'b01: begin
                mis = req_addr[0];
                be  = 8'h03;
                ext = req_unsigned ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            end
            2'b10: begin
                mis = |req_addr[1:0];
                be  = 8'h0F;
                ext = req_unsigned ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            end
            default: begin
                mis = |req_addr[2:0];
                be  = 8'hFF;
                ext = rd_sh;
            end
        endcase
    end

    // Next state of the handshake FSM and the captured response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        oob_d   = oob_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rdata_d = (req_write || err) ? 64'd0 : ext;
                    mis_d   = mis;
                    oob_d   = oob;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; async reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 64'd0;
            mis_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            oob_q   <= oob_d;
        end
    end

    // Byte-lane store at the acceptance edge; errored stores are dropped.
    always_ff @(posedge clk) begin
        if (accept && req_write && !err) begin
            for (int b = 0; b < 8; b++) begin
                if (be_sh[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign resp_oob        = oob_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: three instances at LATENCY 1, 3 and 4.
module tb_dmem_sized;

    localparam int LATS [3] = '{1, 3, 4};

    logic        clk;
    logic        rst_n           [3];
    logic        req_valid       [3];
    logic        req_ready       [3];
    logic        req_write       [3];
    logic [1:0]  req_size        [3];
    logic        req_unsigned    [3];
    logic [63:0] req_addr        [3];
    logic [63:0] req_wdata       [3];
    logic        resp_valid      [3];
    logic [63:0] resp_rdata      [3];
    logic        resp_misaligned [3];
    logic        resp_oob        [3];

    int n_assert = 0;
    int n_fail   = 0;

    logic        got;
    logic [63:0] cap_rdata;
    logic        cap_mis;
    logic        cap_oob;
    logic        seen;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_sized #(.DEPTH(1024), .LATENCY(LATS[g])) u_dut (
            .clk             (clk),
            .rst_n           (rst_n[g]),
            .req_valid       (req_valid[g]),
            .req_ready       (req_ready[g]),
            .req_write       (req_write[g]),
            .req_size        (req_size[g]),
            .req_unsigned    (req_unsigned[g]),
            .req_addr        (req_addr[g]),
            .req_wdata       (req_wdata[g]),
            .resp_valid      (resp_valid[g]),
            .resp_rdata      (resp_rdata[g]),
            .resp_misaligned (resp_misaligned[g]),
            .resp_oob        (resp_oob[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: present, wait for acceptance, capture the response.
    task automatic do_req(input int u, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd);
        int t;
        @(negedge clk);
        req_valid[u]    = 1'b1;
        req_write[u]    = wr;
        req_size[u]     = sz;
        req_unsigned[u] = uns;
        req_addr[u]     = addr;
        req_wdata[u]    = wd;
        t = 0;
        while (!req_ready[u] && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (resp_valid[u]) begin
                got       = 1'b1;
                cap_rdata = resp_rdata[u];
                cap_mis   = resp_misaligned[u];
                cap_oob   = resp_oob[u];
            end
        end
        chk("resp_seen", 64'(got), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i]        = 1'b1;
            req_valid[i]    = 1'b0;
            req_write[i]    = 1'b0;
            req_size[i]     = 2'b00;
            req_unsigned[i] = 1'b0;
            req_addr[i]     = 64'd0;
            req_wdata[i]    = 64'd0;
        end
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
        #2;
        chk("rst_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_valid", 64'(resp_valid[0]), 64'd0);
        chk("rst_rdata", resp_rdata[0], 64'd0);
        chk("rst_mis", 64'(resp_misaligned[0]), 64'd0);
        chk("rst_oob", 64'(resp_oob[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Initial contents
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0);
        chk("ld0_rdata", cap_rdata, 64'h1);
        chk("ld0_mis", 64'(cap_mis), 64'd0);
        chk("ld0_oob", 64'(cap_oob), 64'd0);
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h8, 64'h0);
        chk("ld8_rdata", cap_rdata, 64'hA);

        // Byte store then loads of various widths/extension
        do_req(0, 1'b1, 2'b00, 1'b0, 64'h13, 64'h80);
        chk("sb_rdata", cap_rdata, 64'h0);
        chk("sb_mis", 64'(cap_mis), 64'd0);
        do_req(0, 1'b0, 2'b00, 1'b0, 64'h13, 64'h0);
        chk("lb", cap_rdata, 64'hFFFFFFFFFFFFFF80);
        do_req(0, 1'b0, 2'b00, 1'b1, 64'h13, 64'h0);
        chk("lbu", cap_rdata, 64'h80);
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
        chk("ld10", cap_rdata, 64'h0000000080000000);
        do_req(0, 1'b0, 2'b10, 1'b0, 64'h10, 64'h0);
        chk("lw10", cap_rdata, 64'hFFFFFFFF80000000);
        do_req(0, 1'b0, 2'b10, 1'b1, 64'h10, 64'h0);
        chk("lwu10", cap_rdata, 64'h80000000);
        do_req(0, 1'b0, 2'b01, 1'b0, 64'h12, 64'h0);
        chk("lh12", cap_rdata, 64'hFFFFFFFFFFFF8000);

        // Misaligned store is suppressed
        do_req(0, 1'b1, 2'b10, 1'b0, 64'h6, 64'hDEADBEEF);
        chk("sw_mis", 64'(cap_mis), 64'd1);
        chk("sw_mis_rdata", cap_rdata, 64'h0);
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h0, 64'h0);
        chk("ld0_after_mis", cap_rdata, 64'h1);

        // Out of range
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h2000, 64'h0);
        chk("oob_flag", 64'(cap_oob), 64'd1);
        chk("oob_mis", 64'(cap_mis), 64'd0);
        chk("oob_rdata", cap_rdata, 64'h0);
        do_req(0, 1'b0, 2'b11, 1'b0, 64'h1FF8, 64'h0);
        chk("last_oob", 64'(cap_oob), 64'd0);
        do_req(0, 1'b0, 2'b01, 1'b0, 64'h2001, 64'h0);
        chk("both_oob", 64'(cap_oob), 64'd1);
        chk("both_mis", 64'(cap_mis), 64'd1);

        // Throughput at LATENCY 3: accept at 0,4,8; response in cycles 3,7,11
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_size[1]  = 2'b11;
        req_addr[1]  = 64'h0;
        chk("tp_ready_c0", 64'(req_ready[1]), 64'd1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("tp_ready_c%0d", c), 64'(req_ready[1]), 64'(c % 4 == 0));
            chk($sformatf("tp_valid_c%0d", c), 64'(resp_valid[1]), 64'(c % 4 == 3));
            if (c == 3) chk("tp_rdata", resp_rdata[1], 64'h1);
        end
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during WAIT at LATENCY 4
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_size[2]  = 2'b11;
        req_addr[2]  = 64'h10;
        req_wdata[2] = 64'h1234;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        chk("wait_ready", 64'(req_ready[2]), 64'd0);
        #1 rst_n[2] = 1'b0;
        #1;
        chk("rstw_ready", 64'(req_ready[2]), 64'd1);
        chk("rstw_valid", 64'(resp_valid[2]), 64'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid[2]) seen = 1'b1;
        end
        chk("rstw_no_resp", 64'(seen), 64'd0);
        do_req(2, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
        chk("rstw_ld10", cap_rdata, 64'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
